// File: rtl/build_info_pkg.sv
// Shared types and constants for build_info_reader.
package build_info_pkg;

    localparam int unsigned NUM_WORDS = 6;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IDX_W     = 3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        FINISH
    } state_e;

    // Byte address of word idx; 32-bit wrap-around is intended.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base + {27'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/build_info_timeout.sv
// Per-handshake watchdog for build_info_reader; only present when BUILD_INFO_READER_TIMEOUT_EN is defined.
`ifdef BUILD_INFO_READER_TIMEOUT_EN
module build_info_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run || clear) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle.
    assign expired_c = run && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/build_info_reader.sv
// Read-only AXI4-Lite initiator fetching the build date and 160-bit commit id as six words.
// Optional handshake watchdog enabled by defining BUILD_INFO_READER_TIMEOUT_EN.
module build_info_reader
    import build_info_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         CLK_i,
    input  logic         RST_i,
    input  logic         START_i,
    output logic [31:0]  M_AXI_ARADDR,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,
    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY,
    output logic [31:0]  BUILD_DATE_o,
    output logic [159:0] COMMIT_o,
    output logic         BUSY_o,
    output logic         DONE_o,
    output logic         VALID_o,
    output logic         ERROR_o
);

    localparam int unsigned COMMIT_W = (NUM_WORDS - 1) * WORD_W;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [31:0]         araddr_q, araddr_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic [WORD_W-1:0]   build_date_q, build_date_d;
    logic [COMMIT_W-1:0] commit_q, commit_d;

    logic ar_hs;
    logic r_hs;
    logic timeout_c;

    assign ar_hs = arvalid_q & M_AXI_ARREADY;
    assign r_hs  = rready_q & M_AXI_RVALID;

`ifdef BUILD_INFO_READER_TIMEOUT_EN
    build_info_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLK_i),
        .rst      (RST_i),
        .run      ((state_q == ADDR) || (state_q == DATA)),
        .clear    (ar_hs | r_hs),
        .expired_c(timeout_c)
    );
`else
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
    assign timeout_c = 1'b0;
`endif

    // Next state, capture and registered-output decode.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        valid_d      = valid_q;
        error_d      = error_q;
        build_date_d = build_date_q;
        commit_d     = commit_q;

        case (state_q)
            IDLE: begin
                if (START_i) begin
                    state_d = ADDR;
                    k_d     = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d = DATA;
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            DATA: begin
                if (r_hs) begin
                    if (M_AXI_RRESP != OKAY) begin
                        error_d = 1'b1;
                        state_d = FINISH;
                    end else begin
                        case (k_q)
                            3'd0:    build_date_d      = M_AXI_RDATA;
                            3'd1:    commit_d[159:128] = M_AXI_RDATA;
                            3'd2:    commit_d[127:96]  = M_AXI_RDATA;
                            3'd3:    commit_d[95:64]   = M_AXI_RDATA;
                            3'd4:    commit_d[63:32]   = M_AXI_RDATA;
                            3'd5:    commit_d[31:0]    = M_AXI_RDATA;
                            default: ;
                        endcase
                        if (k_q == IDX_W'(NUM_WORDS - 1)) begin
                            state_d = FINISH;
                        end else begin
                            k_d     = k_q + IDX_W'(1);
                            state_d = ADDR;
                        end
                    end
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != FINISH) && (state_d == FINISH)) begin
            valid_d = ~error_d;
        end

        arvalid_d = (state_d == ADDR);
        rready_d  = (state_d == DATA);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
        araddr_d  = word_addr(BASE_ADDR, k_d);
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q      <= IDLE;
            k_q          <= '0;
            araddr_q     <= BASE_ADDR;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            build_date_q <= '0;
            commit_q     <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            build_date_q <= build_date_d;
            commit_q     <= commit_d;
        end
    end

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign BUSY_o        = busy_q;
    assign DONE_o        = done_q;
    assign VALID_o       = valid_q;
    assign ERROR_o       = error_q;
    assign BUILD_DATE_o  = build_date_q;
    assign COMMIT_o      = commit_q;

endmodule

// File: tb/tb_build_info_reader.sv
// Self-checking bench for build_info_reader: a table of slave timings/faults plus
// mid-operation reset, ignored-start and watchdog sequences, against a scoreboard.
`timescale 1ns/1ps
module tb_build_info_reader;
    import build_info_pkg::*;

    localparam logic [31:0] BASE   = 32'h0000_0040;
    localparam int unsigned TMO    = 16;
    localparam int          NO_ERR = 7;
    localparam int          BUDGET = 400;

    typedef struct {
        int ar_delay;
        int r_delay;
        int err_word;
        int seed;
        bit poke;
        int exp_lat;
        int exp_ar;
    } vec_t;

    typedef struct {
        logic [31:0]  bd;
        logic [159:0] commit;
        logic         valid;
        logic         error;
    } result_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [31:0]  build_date;
    logic [159:0] commit;
    logic         busy;
    logic         done;
    logic         valid;
    logic         error;

    build_info_reader #(
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_i        (clk),
        .RST_i        (rst),
        .START_i      (start),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready),
        .BUILD_DATE_o (build_date),
        .COMMIT_o     (commit),
        .BUSY_o       (busy),
        .DONE_o       (done),
        .VALID_o      (valid),
        .ERROR_o      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          ar_delay = 0;
    int          r_delay  = 0;
    int          err_word = NO_ERR;
    int          seed     = 0;
    bit          ar_block = 1'b0;
    int          ar_cnt   = 0;
    int          r_cnt    = 0;
    int          n_ar     = 0;
    bit          arv_wait = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] held_addr = '0;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    logic [31:0]  m_bd     = '0;
    logic [159:0] m_commit = '0;

    logic [31:0] exp_addr_q[$];
    result_t     exp_res_q[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_data(input int s, input int w);
        if (s == 0) return (w == 0) ? 32'h0000_00BD : 32'h1111_1111 * 32'(w);
        return {8'(s), 8'hC0, 8'(w), 8'h5A};
    endfunction

    task automatic model_capture(input int w, input logic [31:0] d);
        if (w == 0) m_bd = d;
        else m_commit[32*(5-w) +: 32] = d;
    endtask

    // Slave: decides ARREADY/RVALID at each falling edge, so every handshake is known before the rising edge.
    initial begin
        int word;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = OKAY;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready  = 1'b0;
                rvalid   = 1'b0;
                ar_cnt   = 0;
                r_cnt    = 0;
                arv_wait = 1'b0;
            end else begin
                if (arvalid) begin
                    if (arv_wait) check("araddr_stable", 160'(araddr), 160'(held_addr));
                    if (!ar_block && ar_cnt >= ar_delay) begin
                        arready   = 1'b1;
                        n_ar++;
                        ar_cnt    = 0;
                        arv_wait  = 1'b0;
                        pend_addr = araddr;
                        if (exp_addr_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL ar_unexpected: got address %0h expected no request", araddr);
                        end else begin
                            check("araddr_order", 160'(araddr), 160'(exp_addr_q.pop_front()));
                        end
                    end else begin
                        arready   = 1'b0;
                        ar_cnt++;
                        arv_wait  = 1'b1;
                        held_addr = araddr;
                    end
                end else begin
                    arready  = !ar_block && (ar_delay == 0);
                    arv_wait = 1'b0;
                end

                if (rready) begin
                    if (r_cnt >= r_delay) begin
                        rvalid = 1'b1;
                        r_cnt  = 0;
                        word   = int'((pend_addr - BASE) >> 2);
                        if (word == err_word) begin
                            rdata = 32'hBAD0_BAD0;
                            rresp = SLVERR;
                        end else begin
                            rdata = word_data(seed, word);
                            rresp = OKAY;
                        end
                    end else begin
                        rvalid = 1'b0;
                        r_cnt++;
                    end
                end else begin
                    // Garbage on an early RVALID must never be captured.
                    rvalid = (r_delay == 0);
                    rdata  = 32'hDEAD_BEEF;
                    rresp  = DECERR;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_arvalid"}, 160'(arvalid), 160'(0));
        check({tag, "_rready"}, 160'(rready), 160'(0));
        check({tag, "_busy"}, 160'(busy), 160'(0));
        check({tag, "_done"}, 160'(done), 160'(0));
        check({tag, "_valid"}, 160'(valid), 160'(0));
        check({tag, "_error"}, 160'(error), 160'(0));
        check({tag, "_build_date"}, 160'(build_date), 160'(0));
        check({tag, "_commit"}, commit, 160'(0));
    endtask

    task automatic configure(input int ard, input int rd, input int ew, input int s);
        ar_delay = ard;
        r_delay  = rd;
        err_word = ew;
        seed     = s;
        ar_block = 1'b0;
        ar_cnt   = 0;
        r_cnt    = 0;
        n_ar     = 0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("start_clears_valid", 160'(valid), 160'(0));
        check("start_clears_error", 160'(error), 160'(0));
        check("busy_after_start", 160'(busy), 160'(1));
    endtask

    task automatic wait_done(input int exp_lat, input bit poke);
        result_t r;
        int extra;
        while (!done && cyc < BUDGET) begin
            start = poke && (cyc == 3 || cyc == exp_lat - 1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no DONE_o expected one within %0d cycles", BUDGET);
            if (exp_res_q.size() > 0) exp_res_q.delete(0);
            return;
        end
        check("done_latency", 160'(cyc), 160'(exp_lat));
        check("finish_arvalid", 160'(arvalid), 160'(0));
        check("finish_rready", 160'(rready), 160'(0));
        if (exp_res_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got DONE_o expected no completion");
        end else begin
            r = exp_res_q.pop_front();
            check("build_date", 160'(build_date), 160'(r.bd));
            check("commit", commit, r.commit);
            check("valid", 160'(valid), 160'(r.valid));
            check("error", 160'(error), 160'(r.error));
        end
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 160'(done), 160'(0));
        check("idle_after_finish", 160'(busy), 160'(0));
        if (poke) begin
            extra = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("ignored_start_activity", 160'(extra), 160'(0));
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit err;
        int nw;
        int ncap;
        err  = (v.err_word < int'(NUM_WORDS));
        nw   = err ? v.err_word + 1 : int'(NUM_WORDS);
        ncap = err ? v.err_word : int'(NUM_WORDS);
        configure(v.ar_delay, v.r_delay, v.err_word, v.seed);
        for (int w = 0; w < nw; w++) exp_addr_q.push_back(BASE + 32'(4 * w));
        for (int w = 0; w < ncap; w++) model_capture(w, word_data(v.seed, w));
        exp_res_q.push_back('{m_bd, m_commit, !err, err});
        start_pulse();
        wait_done(v.exp_lat, v.poke);
        check("ar_handshakes", 160'(n_ar), 160'(v.exp_ar));
        check("addr_queue_drained", 160'(exp_addr_q.size()), 160'(0));
        exp_addr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: got simulation still running expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int   guard;
        bit   stayed;

        //         ard rd err     seed poke lat ar
        vecs[0] = '{0, 0, NO_ERR, 0, 1'b0, 13, 6};
        vecs[1] = '{3, 5, NO_ERR, 1, 1'b0, 61, 6};
        vecs[2] = '{0, 0, 2,      2, 1'b0,  7, 3};
        vecs[3] = '{1, 2, 0,      3, 1'b0,  6, 1};
        vecs[4] = '{0, 0, 5,      4, 1'b0, 13, 6};
        vecs[5] = '{2, 1, NO_ERR, 5, 1'b1, 31, 6};
        vecs[6] = '{0, 0, NO_ERR, 6, 1'b0, 13, 6};

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while waiting for the fourth word's data.
        configure(1, 5, NO_ERR, 7);
        for (int w = 0; w < int'(NUM_WORDS); w++) exp_addr_q.push_back(BASE + 32'(4 * w));
        start_pulse();
        guard = 0;
        while (!(n_ar == 4 && rready) && guard < BUDGET) begin
            @(negedge clk);
            guard++;
        end
        check("reached_word3_data", 160'(n_ar == 4 && rready), 160'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        exp_addr_q.delete();
        m_bd     = '0;
        m_commit = '0;
        run_vec('{0, 0, NO_ERR, 8, 1'b0, 13, 6});

        // Slave that never accepts the address.
        configure(0, 0, NO_ERR, 9);
        ar_block = 1'b1;
`ifdef BUILD_INFO_READER_TIMEOUT_EN
        exp_res_q.push_back('{m_bd, m_commit, 1'b0, 1'b1});
        start_pulse();
        wait_done(int'(TMO) + 1, 1'b0);
        check("timeout_no_handshake", 160'(n_ar), 160'(0));
`else
        start_pulse();
        stayed = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (!busy || done || !arvalid) stayed = 1'b0;
        end
        check("busy_held_1000", 160'(stayed), 160'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("busy_cleared_by_reset", 160'(busy), 160'(0));
        m_bd     = '0;
        m_commit = '0;
`endif
        ar_block = 1'b0;
        run_vec('{0, 0, NO_ERR, 10, 1'b0, 13, 6});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/build_info_reader.md
BUILD_INFO_READER -- requirements
Module: build_info_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of the build-date register on the AXI4-Lite slave.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, the maximum number of cycles to wait per AXI handshake.
REQ-003 CLK_i  input  1  sole clock; one clock, reset is synchronous and active-high.
REQ-004 RST_i  input  1  synchronous, active-high reset.
REQ-005 START_i  input  1  level sampled in IDLE; starts one read sequence.
REQ-006 M_AXI_ARADDR  output  32  read address; M_AXI_ARVALID output 1; M_AXI_ARREADY input 1.
REQ-007 M_AXI_RDATA  input  32; M_AXI_RRESP input 2; M_AXI_RVALID input 1; M_AXI_RREADY output 1.
REQ-008 BUILD_DATE_o  output  32  captured word 0.
REQ-009 COMMIT_o  output  160  captured words 1..5; word 1 goes to [159:128] and word 5 to [31:0].
REQ-010 BUSY_o  output  1; DONE_o output 1 (one-cycle pulse); VALID_o output 1 (level, data good); ERROR_o output 1 (level).

Function
REQ-011 SHALL be a read-only AXI4-Lite initiator with exactly one outstanding transaction; it has no write-channel ports.
REQ-012 FSM states: IDLE, ADDR, DATA, FINISH.
- IDLE->ADDR when START_i=1.
- ADDR->DATA on the ARVALID&ARREADY handshake.
- DATA->ADDR on the RVALID&RREADY handshake when word<5.
- DATA->FINISH on that handshake when word=5, or on error.
- FINISH->IDLE unconditionally.
REQ-013 Word index k (3 bits) SHALL run 0..5; M_AXI_ARADDR = BASE_ADDR + 4*k, 32-bit wrap-around addition.
REQ-014 ARVALID=1 throughout ADDR; ARADDR stable while ARVALID=1; ARVALID never deasserted before ARREADY, except by reset.
REQ-015 RREADY=1 only in DATA; RDATA captured into the word-k output field on the R handshake cycle.
REQ-016 RRESP != 2'b00 SHALL discard RDATA, set ERROR_o, abort to FINISH; remaining words are not read.
REQ-017 DONE_o=1 for exactly the FINISH cycle; VALID_o set in FINISH only if ERROR_o=0.
REQ-018 START_i in IDLE SHALL clear VALID_o and ERROR_o; START_i outside IDLE is ignored.
REQ-019 BUSY_o=1 in ADDR, DATA and FINISH.
REQ-020 Latency: with ARREADY=1 and RVALID=1 continuously, DONE_o SHALL assert exactly 13 cycles after the START_i sampling edge.
REQ-021 ARREADY and RVALID arriving in the same cycle while in ADDR: only the AR handshake counts; RVALID is consumed in DATA.

Reset
REQ-022 RST_i=1 at a clock edge SHALL force IDLE, k=0, ARVALID=0, RREADY=0, BUSY_o=0, DONE_o=0, VALID_o=0, ERROR_o=0, BUILD_DATE_o=0 and COMMIT_o=0, including mid-transaction.

Configuration
REQ-023 Macro BUILD_INFO_READER_TIMEOUT_EN defined:
- A counter runs in ADDR and DATA and clears on each handshake.
- Reaching TIMEOUT_CYCLES sets ERROR_o and goes to FINISH, dropping ARVALID and RREADY.
REQ-024 Macro undefined: no counter; ADDR and DATA wait indefinitely; TIMEOUT_CYCLES is unused.

Structure
REQ-025 Package build_info_pkg SHALL hold:
- the FSM state enum;
- NUM_WORDS=6;
- the RRESP constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-026 Sub-module build_info_timeout SHALL hold the watchdog counter, instantiated only under BUILD_INFO_READER_TIMEOUT_EN.

Verification
REQ-027 Zero-wait slave:
- Stimulus: word0=32'h000000BD, commit words 32'h11111111..32'h55555555, START_i pulse.
- Response: DONE_o pulse at cycle 13; BUILD_DATE_o=32'h000000BD; COMMIT_o=160'h11111111_22222222_33333333_44444444_55555555; VALID_o=1; ERROR_o=0.
REQ-028 Slow slave:
- Stimulus: ARREADY delayed 3 cycles, RVALID delayed 5 cycles, BASE_ADDR=32'h40.
- Response: addresses 32'h40,32'h44,32'h48,32'h4C,32'h50,32'h54 in order; ARADDR stable while ARVALID=1; correct data captured.
REQ-029 RRESP fault:
- Stimulus: RRESP=2'b10 on word 2.
- Response: ERROR_o=1, VALID_o=0, DONE_o pulse, exactly 3 AR handshakes.
REQ-030 Reset mid-operation:
- Stimulus: RST_i asserted in DATA of word 3.
- Response: all outputs 0 the next cycle; a new START_i performs a clean 6-word read.
REQ-031 Timeout (macro defined, TIMEOUT_CYCLES=16):
- Stimulus: ARREADY held at 0.
- Response: ERROR_o=1 and DONE_o after 16 cycles in ADDR.
- Macro undefined: BUSY_o stays 1 for 1000 cycles.
REQ-032 Ignored start:
- Stimulus: START_i pulsed while BUSY_o=1.
- Response: exactly 6 AR handshakes and one DONE_o pulse.
